uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum payload bytes per frame (legal 1..255).
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 Parameter TIMEOUT_CLKS, default 4340: max clocks between bytes inside a frame (two byte times at CLKS_PER_BIT=217).
REQ-004 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_Rx_DV  input  1  one-cycle strobe, byte available from UART receiver.
REQ-007 i_Rx_Byte  input  8  received byte, valid when i_Rx_DV=1.
REQ-008 o_Data  output  8  payload byte to consumer.
REQ-009 o_Data_Valid  output  1  o_Data valid; held until accepted.
REQ-010 i_Data_Ready  input  1  consumer accepts o_Data when o_Data_Valid=1 and i_Data_Ready=1.
REQ-011 o_Last  output  1  high with o_Data_Valid on final payload byte.
REQ-012 o_Err  output  1  one-cycle pulse on frame error.
REQ-013 o_Err_Code  output  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout.
REQ-014 o_Overrun  output  1  one-cycle pulse when a byte is dropped during OUTPUT.
REQ-015 o_Frame_Count  output  16  count of good frames, wraps 16'hFFFF -> 0.

Function
REQ-016 Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-017 States: IDLE, LEN, PAYLOAD, CHECK, OUTPUT; bytes consumed only on cycles with i_Rx_DV=1.
REQ-018 IDLE: byte == SYNC_BYTE -> LEN; any other byte discarded, no error.
REQ-019 LEN: LEN==0 or LEN>MAX_LEN -> IDLE, o_Err pulse, code 1; else store LEN, seed running XOR with LEN, clear write index -> PAYLOAD.
REQ-020 PAYLOAD: each byte written to internal buffer[index], XOR updated, index incremented; after LEN-th byte -> CHECK.
REQ-021 CHECK: next byte compared to running XOR; match -> OUTPUT, o_Frame_Count +1 same cycle; mismatch -> IDLE, o_Err pulse, code 2.
REQ-022 OUTPUT: o_Data_Valid asserted the cycle after CHECK completes; buffer[0..LEN-1] presented in order; index advances only on handshake; o_Data/o_Last stable while stalled.
REQ-023 Handshake on final byte -> IDLE, o_Data_Valid low next cycle; back-to-back frames may begin immediately in IDLE.
REQ-024 i_Rx_DV=1 in OUTPUT: byte discarded, o_Overrun pulses next cycle; state unaffected.
REQ-025 Timeout counter clears on every i_Rx_DV and on entry to LEN; increments each clock in LEN, PAYLOAD, CHECK; reaching TIMEOUT_CLKS -> IDLE, o_Err pulse, code 3; counter inactive in IDLE and OUTPUT.
REQ-026 Timeout and i_Rx_DV in same cycle: byte takes priority, counter clears, no error.
REQ-027 SYNC_BYTE value inside LEN/PAYLOAD/CHECK is treated as data, not resynchronisation.
REQ-028 o_Err and o_Overrun pulses registered, exactly one cycle wide; o_Err_Code updates same cycle as o_Err and holds otherwise.
REQ-029 Latency: first o_Data_Valid exactly 1 cycle after the i_Rx_DV cycle carrying a correct CHK.
REQ-030 Undefined state encoding -> IDLE next cycle.

Reset
REQ-031 reset_n low asynchronously forces IDLE; o_Data_Valid, o_Last, o_Err, o_Overrun = 0; o_Err_Code = 0; o_Frame_Count = 0; o_Data = 8'h00; indices, XOR, timeout counter = 0.
REQ-032 Reset mid-frame or mid-OUTPUT abandons the frame with no error and no further output; buffer contents need not be cleared.
REQ-033 After reset_n rises, first byte processed is the first i_Rx_DV on or after the following clock edge.

Verification
REQ-034 A5,03,11,22,33,CHK=03^11^22^33=03, i_Data_Ready=1 -> o_Data 11,22,33 on consecutive cycles, o_Last with 33, o_Frame_Count=1.
REQ-035 Same frame, i_Data_Ready low 5 cycles per byte -> each byte held stable, no loss, o_Last only on 33.
REQ-036 A5,02,AA,BB,CHK=00 (correct 13) -> single o_Err pulse, o_Err_Code=2, no o_Data_Valid, count unchanged.
REQ-037 A5,00 and A5,11 (MAX_LEN=16) -> o_Err code 1 each; then valid frame accepted normally.
REQ-038 A5,04,01 then silence 4340 clocks -> o_Err code 3 exactly at TIMEOUT_CLKS; following 5A,A5,01,7E,7F -> o_Data 7E with o_Last.
REQ-039 Byte arriving during stalled OUTPUT -> o_Overrun pulse, output stream intact; reset_n asserted mid-OUTPUT -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SYNC/LEN/payload/XOR-checksum frame parser with buffered handshake output
module uart_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic        i_Clock,
  input  logic        reset_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [7:0]  o_Data,
  output logic        o_Data_Valid,
  input  logic        i_Data_Ready,
  output logic        o_Last,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Overrun,
  output logic [15:0] o_Frame_Count
);

  // Buffer is rounded up to a power of two so every index slice is exactly wide enough.
  localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << IW;
  localparam int TW    = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]    state;
  logic [7:0]    len;
  logic [7:0]    wr_idx;
  logic [7:0]    rd_idx;
  logic [7:0]    xor_acc;
  logic [TW-1:0] to_cnt;
  logic [7:0]    buffer [DEPTH];

  logic [7:0] rd_next;
  logic       in_frame;
  logic       to_hit;

  assign rd_next  = rd_idx + 8'd1;
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
  assign to_hit   = (to_cnt == TO_LAST);

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_Clock) begin
    if (state == S_PAYLOAD && i_Rx_DV)
      buffer[wr_idx[IW-1:0]] <= i_Rx_Byte;
  end

  // Frame FSM, checksum, output stream, error/overrun pulses and inter-byte watchdog.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      len           <= 8'd0;
      wr_idx        <= 8'd0;
      rd_idx        <= 8'd0;
      xor_acc       <= 8'd0;
      to_cnt        <= '0;
      o_Data        <= 8'h00;
      o_Data_Valid  <= 1'b0;
      o_Last        <= 1'b0;
      o_Err         <= 1'b0;
      o_Err_Code    <= 2'd0;
      o_Overrun     <= 1'b0;
      o_Frame_Count <= 16'd0;
    end else begin
      o_Err     <= 1'b0;
      o_Overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE)
            state <= S_LEN;
        end

        S_LEN: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN_B) begin
              state      <= S_IDLE;
              o_Err      <= 1'b1;
              o_Err_Code <= 2'd1;
            end else begin
              len     <= i_Rx_Byte;
              xor_acc <= i_Rx_Byte;
              wr_idx  <= 8'd0;
              state   <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (i_Rx_DV) begin
            xor_acc <= xor_acc ^ i_Rx_Byte;
            wr_idx  <= wr_idx + 8'd1;
            if (wr_idx + 8'd1 == len)
              state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == xor_acc) begin
              state         <= S_OUTPUT;
              o_Frame_Count <= o_Frame_Count + 16'd1;
              rd_idx        <= 8'd0;
              o_Data        <= buffer[0];
              o_Data_Valid  <= 1'b1;
              o_Last        <= (len == 8'd1);
            end else begin
              state      <= S_IDLE;
              o_Err      <= 1'b1;
              o_Err_Code <= 2'd2;
            end
          end
        end

        S_OUTPUT: begin
          // Receiver has no backpressure, so bytes arriving now are lost and flagged.
          if (i_Rx_DV)
            o_Overrun <= 1'b1;
          if (o_Data_Valid && i_Data_Ready) begin
            if (o_Last) begin
              state        <= S_IDLE;
              o_Data_Valid <= 1'b0;
              o_Last       <= 1'b0;
            end else begin
              rd_idx <= rd_next;
              o_Data <= buffer[rd_next[IW-1:0]];
              o_Last <= (rd_next == len - 8'd1);
            end
          end
        end

        default: begin
          state        <= S_IDLE;
          o_Data_Valid <= 1'b0;
          o_Last       <= 1'b0;
        end
      endcase

      // Watchdog only runs while a frame is being collected; an arriving byte always wins.
      if (in_frame) begin
        if (i_Rx_DV) begin
          to_cnt <= '0;
        end else if (to_hit) begin
          state      <= S_IDLE;
          o_Err      <= 1'b1;
          o_Err_Code <= 2'd3;
          to_cnt     <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed bench with queue-based frame model and per-cycle compare
module tb_uart_frame_parser;

  localparam int         MAX_LEN      = 16;
  localparam logic [7:0] SYNC         = 8'hA5;
  localparam int         TIMEOUT_CLKS = 4340;

  logic        i_Clock;
  logic        reset_n;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic [7:0]  o_Data;
  logic        o_Data_Valid;
  logic        i_Data_Ready;
  logic        o_Last;
  logic        o_Err;
  logic [1:0]  o_Err_Code;
  logic        o_Overrun;
  logic [15:0] o_Frame_Count;

  int vectors;
  int miscompares;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .i_Clock(i_Clock), .reset_n(reset_n), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Data(o_Data), .o_Data_Valid(o_Data_Valid), .i_Data_Ready(i_Data_Ready),
    .o_Last(o_Last), .o_Err(o_Err), .o_Err_Code(o_Err_Code), .o_Overrun(o_Overrun),
    .o_Frame_Count(o_Frame_Count)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the frame being collected, bytes owed to the consumer, and expectations.
  logic [7:0]  pend[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  dlog[$];
  int          silence;
  logic [15:0] exp_count;
  logic [1:0]  exp_code;
  bit          err_now;
  bit          ovr_now;
  int          ovr_seen;

  always @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      pend.delete();
      exp_q.delete();
      silence   = 0;
      exp_count = 16'd0;
      exp_code  = 2'd0;
      err_now   = 0;
      ovr_now   = 0;
    end else begin
      err_now = 0;
      ovr_now = 0;
      if (exp_q.size() > 0) begin
        if (i_Rx_DV) ovr_now = 1;
        if (i_Data_Ready) void'(exp_q.pop_front());
      end else if (i_Rx_DV) begin
        silence = 0;
        if (pend.size() == 0) begin
          if (i_Rx_Byte == SYNC) pend.push_back(i_Rx_Byte);
        end else begin
          pend.push_back(i_Rx_Byte);
          if (pend.size() == 2 && (i_Rx_Byte == 8'd0 || int'(i_Rx_Byte) > MAX_LEN)) begin
            err_now = 1; exp_code = 2'd1; pend.delete();
          end else if (pend.size() >= 2 && pend.size() == int'(pend[1]) + 3) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 1; i < pend.size() - 1; i++) x = x ^ pend[i];
            if (x == i_Rx_Byte) begin
              for (int i = 2; i < pend.size() - 1; i++) exp_q.push_back(pend[i]);
              exp_count = exp_count + 16'd1;
            end else begin
              err_now = 1; exp_code = 2'd2;
            end
            pend.delete();
          end
        end
      end else if (pend.size() > 0) begin
        silence++;
        if (silence == TIMEOUT_CLKS) begin
          err_now = 1; exp_code = 2'd3; pend.delete(); silence = 0;
        end
      end
    end
  end

  // Every cycle out of reset: compare all DUT outputs to the model.
  always @(negedge i_Clock) begin
    if (reset_n) begin
      check("valid", o_Data_Valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("data", o_Data, exp_q[0]);
        check("last", o_Last, exp_q.size() == 1);
        if (o_Data_Valid && i_Data_Ready) dlog.push_back(o_Data);
      end else begin
        check("last_idle", o_Last, 0);
      end
      check("err", o_Err, err_now);
      check("err_code", o_Err_Code, exp_code);
      check("overrun", o_Overrun, ovr_now);
      check("frame_count", o_Frame_Count, exp_count);
      if (o_Overrun) ovr_seen++;
    end
  end

  task automatic send(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock); #1;
    i_Rx_DV   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_Clock); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((o_Data_Valid || exp_q.size() > 0) && n < 400) begin
      @(posedge i_Clock); #1; n++;
    end
    check("drain_done", o_Data_Valid, 0);
  endtask

  task automatic check_log3(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input int n);
    check({name, "_len"}, dlog.size(), n);
    if (n > 0 && dlog.size() > 0) check({name, "_0"}, dlog[0], a);
    if (n > 1 && dlog.size() > 1) check({name, "_1"}, dlog[1], b);
    if (n > 2 && dlog.size() > 2) check({name, "_2"}, dlog[2], c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] x;
    vectors = 0; miscompares = 0; ovr_seen = 0;
    reset_n = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Data_Ready = 1'b1;
    idle(3);
    check("rst_valid", o_Data_Valid, 0);
    check("rst_data", o_Data, 8'h00);
    check("rst_last", o_Last, 0);
    check("rst_err", o_Err, 0);
    check("rst_code", o_Err_Code, 0);
    check("rst_ovr", o_Overrun, 0);
    check("rst_count", o_Frame_Count, 0);
    reset_n = 1'b1;
    idle(2);

    // Basic frame, consumer always ready.
    dlog.delete();
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    check("t1_latency_valid", o_Data_Valid, 1);
    check("t1_first_data", o_Data, 8'h11);
    check("t1_count", o_Frame_Count, 16'd1);
    drain();
    check_log3("t1_log", 8'h11, 8'h22, 8'h33, 3);

    // Same frame with a stalled consumer.
    dlog.delete();
    i_Data_Ready = 1'b0;
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    repeat (3) begin
      idle(5);
      i_Data_Ready = 1'b1;
      @(posedge i_Clock); #1;
      i_Data_Ready = 1'b0;
    end
    i_Data_Ready = 1'b1;
    drain();
    check_log3("t2_log", 8'h11, 8'h22, 8'h33, 3);
    check("t2_count", o_Frame_Count, 16'd2);

    // Bad checksum.
    send(SYNC); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    check("t3_err", o_Err, 1);
    check("t3_code", o_Err_Code, 2'd2);
    idle(1);
    check("t3_err_width", o_Err, 0);
    check("t3_code_hold", o_Err_Code, 2'd2);
    check("t3_count", o_Frame_Count, 16'd2);

    // Length out of range, then a full MAX_LEN frame.
    send(SYNC); send(8'h00);
    check("t4_len0_err", o_Err, 1);
    check("t4_len0_code", o_Err_Code, 2'd1);
    idle(2);
    send(SYNC); send(8'h11);
    check("t4_len17_err", o_Err, 1);
    check("t4_len17_code", o_Err_Code, 2'd1);
    idle(2);
    dlog.delete();
    send(SYNC); send(8'h10);
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 3 + 1));
      x = x ^ 8'(i * 3 + 1);
    end
    send(x);
    drain();
    check("t4_maxlen_bytes", dlog.size(), 16);
    if (dlog.size() == 16) check("t4_maxlen_tail", dlog[15], 8'd46);
    check("t4_count", o_Frame_Count, 16'd3);

    // Inter-byte timeout, then garbage and a one-byte frame.
    send(SYNC); send(8'h04); send(8'h01);
    n = 0;
    while (!o_Err && n < 5000) begin
      @(posedge i_Clock); #1; n++;
    end
    check("t5_timeout_clks", n, TIMEOUT_CLKS);
    check("t5_code", o_Err_Code, 2'd3);
    idle(2);
    dlog.delete();
    send(8'h5A); send(SYNC); send(8'h01); send(8'h7E); send(8'h7F);
    check("t5_data", o_Data, 8'h7E);
    check("t5_last", o_Last, 1);
    drain();
    check_log3("t5_log", 8'h7E, 8'h00, 8'h00, 1);

    // SYNC value inside a frame is payload; back-to-back frames.
    dlog.delete();
    send(SYNC); send(8'h02); send(SYNC); send(8'h01); send(8'hA6);
    drain();
    send(SYNC); send(8'h01); send(8'h42); send(8'h43);
    drain();
    check_log3("t6_log", SYNC, 8'h01, 8'h42, 3);
    check("t6_count", o_Frame_Count, 16'd6);

    // Overrun during a stalled output.
    dlog.delete();
    ovr_seen = 0;
    i_Data_Ready = 1'b0;
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    idle(2);
    send(8'h55);
    check("t7_overrun", o_Overrun, 1);
    idle(1);
    check("t7_overrun_width", o_Overrun, 0);
    i_Data_Ready = 1'b1;
    drain();
    check_log3("t7_log", 8'h11, 8'h22, 8'h33, 3);
    check("t7_ovr_seen", ovr_seen, 1);

    // Asynchronous reset in the middle of output.
    i_Data_Ready = 1'b0;
    send(SYNC); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    idle(2);
    #3;
    reset_n = 1'b0;
    #1;
    check("t8_rst_valid", o_Data_Valid, 0);
    check("t8_rst_data", o_Data, 8'h00);
    check("t8_rst_last", o_Last, 0);
    check("t8_rst_count", o_Frame_Count, 0);
    @(posedge i_Clock); #1;
    reset_n = 1'b1;
    i_Data_Ready = 1'b1;
    dlog.delete();
    send(SYNC); send(8'h01); send(8'h7E); send(8'h7F);
    check("t8_after_valid", o_Data_Valid, 1);
    drain();
    check("t8_after_count", o_Frame_Count, 16'd1);
    check_log3("t8_log", 8'h7E, 8'h00, 8'h00, 1);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
